// File: rtl/serial_pair_adder.sv
// Multi-cycle adder: walks two WIDTH-bit operands through one 2-bit slice, LS pair first.
// Optional subtract mode via `SERIAL_PAIR_SUB_EN (adds input 'sub').
module serial_pair_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_PAIR_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("serial_pair_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] partial_q;
    logic [WIDTH-1:0] partial_d;
    logic             carry_q;
    logic [CNT_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] b_in;
    logic             carry_in;

`ifdef SERIAL_PAIR_SUB_EN
    // Subtraction as a + ~b + 1; cout=1 then means no borrow.
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub | cin;
`else
    assign b_in     = b;
    assign carry_in = cin;
`endif

    logic [CNT_W:0] bit_idx;
    logic [1:0]     a_pair;
    logic [1:0]     b_pair;
    logic [2:0]     slice;
    logic           last_pair;

    always_comb begin
        bit_idx   = {idx_q, 1'b0};
        a_pair    = a_q[bit_idx +: 2];
        b_pair    = b_q[bit_idx +: 2];
        slice     = {1'b0, a_pair} + {1'b0, b_pair} + {2'b00, carry_q};
        partial_d = partial_q;
        partial_d[bit_idx +: 2] = slice[1:0];
        last_pair = (idx_q == CNT_W'(WIDTH/2 - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    partial_q <= partial_d;
                    carry_q   <= slice[2];
                    idx_q     <= idx_q + CNT_W'(1);
                    if (last_pair) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= partial_d;
                        cout_q  <= slice[2];
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        a_q       <= a;
                        b_q       <= b_in;
                        carry_q   <= carry_in;
                        partial_q <= '0;
                        idx_q     <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_pair_adder.sv
// Self-checking bench for serial_pair_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_pair_adder;

    localparam int W   = 8;
    localparam int LAT = W / 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    serial_pair_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_PAIR_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
        if (s)
            return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else
            return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tci, input logic ts);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        cin   = tci;
        sub   = ts;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat = negedge index (0 = right after the accepting edge) at which done is seen, -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt, output bit held);
        lat = -1;
        busy_cnt = 0;
        held = 1'b1;
        for (int k = 0; k < 4*LAT + 4; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                return;
            end
            if (busy) busy_cnt++;
            if (sum !== exp_sum || cout !== exp_cout) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
            n_tests++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
            n_tests++;
            if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h want=00", sum); end
            n_tests++;
            if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", cout); end
        end
    endtask

    task automatic run_checked(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tci, input logic ts);
        logic [W:0] r;
        int lat, bc;
        bit held;
        r = ref_op(ta, tb_v, tci, ts);
        drive(ta, tb_v, tci, ts);
        wait_done(lat, bc, held);
        n_tests++;
        if (lat != LAT) begin n_fail++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
        n_tests++;
        if (bc != LAT) begin n_fail++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bc, LAT); end
        n_tests++;
        if (!held) begin n_fail++; $display("FAIL %s_sum_held got=changed want=held at %h", name, exp_sum); end
        n_tests++;
        if (sum !== r[W-1:0]) begin n_fail++; $display("FAIL %s_sum got=%h want=%h", name, sum, r[W-1:0]); end
        n_tests++;
        if (cout !== r[W]) begin n_fail++; $display("FAIL %s_cout got=%b want=%b", name, cout, r[W]); end
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
    endtask

    task automatic test_basic();
        @(negedge clk);
        run_checked("basic", 8'h5A, 8'h33, 1'b0, 1'b0);
        n_tests++;
        if (sum !== 8'h8D) begin n_fail++; $display("FAIL basic_const got=%h want=8d", sum); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b want=0", done); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_checked("b2b_first", 8'hFF, 8'h01, 1'b0, 1'b0);
        // Issue the next op from within the DONE cycle.
        run_checked("b2b_second", 8'hFF, 8'hFF, 1'b1, 1'b0);
        n_tests++;
        if ({cout, sum} !== 9'h1FF) begin n_fail++; $display("FAIL b2b_const got=%h want=1ff", {cout, sum}); end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        bit held;
        logic [W-1:0] prev;
        @(negedge clk);
        prev = exp_sum;
        drive(8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(8'hAA, 8'h55, 1'b1, 1'b0);
        n_tests++;
        if (sum !== prev) begin n_fail++; $display("FAIL ignore_sum_held got=%h want=%h", sum, prev); end
        wait_done(lat, bc, held);
        n_tests++;
        if (lat != LAT - 2) begin n_fail++; $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT - 2); end
        n_tests++;
        if (!held) begin n_fail++; $display("FAIL ignore_held got=changed want=%h", prev); end
        n_tests++;
        if (sum !== 8'h30) begin n_fail++; $display("FAIL ignore_sum got=%h want=30", sum); end
        n_tests++;
        if (cout !== 1'b0) begin n_fail++; $display("FAIL ignore_cout got=%b want=0", cout); end
        exp_sum  = 8'h30;
        exp_cout = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart got=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge clk);
        drive(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b want=0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done got=%b want=0", done); end
        n_tests++;
        if (sum !== '0) begin n_fail++; $display("FAIL areset_sum got=%h want=00", sum); end
        n_tests++;
        if (cout !== 1'b0) begin n_fail++; $display("FAIL areset_cout got=%b want=0", cout); end
        exp_sum  = '0;
        exp_cout = 1'b0;
        @(negedge clk) reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 2*LAT; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL areset_no_done got=%0d want=0", seen); end
        run_checked("areset_after", 8'h12, 8'h34, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic rc, rs;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_PAIR_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_checked("random", ra, rb, rc, rs);
        end
    endtask

`ifdef SERIAL_PAIR_SUB_EN
    task automatic test_sub();
        @(negedge clk);
        run_checked("sub_nob", 8'h10, 8'h01, 1'b0, 1'b1);
        n_tests++;
        if ({cout, sum} !== 9'h10F) begin n_fail++; $display("FAIL sub_nob_const got=%h want=10f", {cout, sum}); end
        @(negedge clk);
        run_checked("sub_borrow", 8'h01, 8'h02, 1'b1, 1'b1);
        n_tests++;
        if ({cout, sum} !== 9'h0FF) begin n_fail++; $display("FAIL sub_borrow_const got=%h want=0ff", {cout, sum}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
`ifdef SERIAL_PAIR_SUB_EN
        test_sub();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
